// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio record/playback buffer.
package audio_pkg;

    localparam int unsigned DEF_DATA_W   = 24;
    localparam int unsigned DEF_CHANNELS = 2;
    localparam int unsigned DEF_DEPTH    = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } state_t;

    // Bits in one multi-channel frame; channel 0 occupies the LSBs.
    function automatic int unsigned frame_width(input int unsigned data_w,
                                                input int unsigned channels);
        return data_w * channels;
    endfunction

endpackage

// File: rtl/audio_loop_buffer_if.sv
// Control, sample and status signals between the audio path and the loop buffer.
interface audio_loop_buffer_if
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned DEPTH    = DEF_DEPTH
);
    localparam int unsigned FW = frame_width(DATA_W, CHANNELS);
    localparam int unsigned AW = $clog2(DEPTH);

    logic          new_sample;
    logic          start_write;
    logic          start_read;
    logic          stop;
    logic          loop_en;
    logic [FW-1:0] in_data;
    logic [FW-1:0] out_data;
    logic          readReady;
    logic          writeComplete;
    logic          busy;
    logic [AW:0]   fill_count;

    modport master (
        output new_sample, start_write, start_read, stop, loop_en, in_data,
        input  out_data, readReady, writeComplete, busy, fill_count
    );

    modport slave (
        input  new_sample, start_write, start_read, stop, loop_en, in_data,
        output out_data, readReady, writeComplete, busy, fill_count
    );

endinterface

// File: rtl/audio_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
module audio_frame_ram #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/audio_loop_buffer.sv
// Record/playback frame buffer with variable length, early stop and loop mode.
module audio_loop_buffer
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned DEPTH    = DEF_DEPTH
) (
    input logic                clk,
    input logic                RESET,
    audio_loop_buffer_if.slave bus
);

    localparam int unsigned FW = frame_width(DATA_W, CHANNELS);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    state_t        state;
    state_t        state_next;

    logic          sample_q;
    logic          start_write_q;
    logic          start_read_q;
    logic          sample_evt;
    logic          write_evt;
    logic          read_evt;

    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] fill_q;
    logic          loop_q;
    logic          rd_valid_q;
    logic [FW-1:0] ram_q;

    logic [FW-1:0] out_data_q;
    logic          read_ready_q;
    logic          write_complete_q;
    logic          busy_q;

    logic          wr_en;
    logic          rd_en;
    logic          rec_start;
    logic          rec_done;
    logic          play_start;
    logic          full;
    logic          last;

    assign sample_evt = bus.new_sample  & ~sample_q;
    assign write_evt  = bus.start_write & ~start_write_q;
    assign read_evt   = bus.start_read  & ~start_read_q;

    assign full = (fill_q == CW'(DEPTH - 1));
    assign last = (CW'(rd_addr) == (fill_q - CW'(1)));

    // Previous-cycle copies of the strobes for rising-edge detection.
    always_ff @(posedge clk) begin
        if (RESET) begin
            sample_q      <= 1'b0;
            start_write_q <= 1'b0;
            start_read_q  <= 1'b0;
        end else begin
            sample_q      <= bus.new_sample;
            start_write_q <= bus.start_write;
            start_read_q  <= bus.start_read;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rec_start  = 1'b0;
        rec_done   = 1'b0;
        play_start = 1'b0;
        case (state)
            IDLE: begin
                if (write_evt) begin
                    state_next = RECORD;
                    rec_start  = 1'b1;
                end else if (read_evt && (fill_q != '0)) begin
                    state_next = PLAY;
                    play_start = 1'b1;
                end
            end
            RECORD: begin
                wr_en = sample_evt;
                if (bus.stop || (sample_evt && full)) begin
                    state_next = IDLE;
                    rec_done   = 1'b1;
                end
            end
            PLAY: begin
                rd_en = sample_evt;
                if (bus.stop || (sample_evt && last && !loop_q)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address, fill and status counters.
    always_ff @(posedge clk) begin
        if (RESET) begin
            wr_addr          <= '0;
            rd_addr          <= '0;
            fill_q           <= '0;
            loop_q           <= 1'b0;
            write_complete_q <= 1'b0;
            busy_q           <= 1'b0;
            rd_valid_q       <= 1'b0;
        end else begin
            busy_q     <= (state_next != IDLE);
            rd_valid_q <= rd_en;
            if (rec_start) begin
                wr_addr          <= '0;
                fill_q           <= '0;
                write_complete_q <= 1'b0;
            end
            if (wr_en) begin
                wr_addr <= wr_addr + AW'(1);
                fill_q  <= fill_q + CW'(1);
            end
            if (rec_done) begin
                write_complete_q <= wr_en || (fill_q != '0);
            end
            if (play_start) begin
                rd_addr <= '0;
                loop_q  <= bus.loop_en;
            end
            if (rd_en) begin
                rd_addr <= last ? '0 : rd_addr + AW'(1);
            end
        end
    end

    // Output stage: present the frame read on the previous edge.
    always_ff @(posedge clk) begin
        if (RESET) begin
            out_data_q   <= '0;
            read_ready_q <= 1'b0;
        end else begin
            read_ready_q <= rd_valid_q;
            if (rd_valid_q) begin
                out_data_q <= ram_q;
            end
        end
    end

    audio_frame_ram #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (bus.in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    assign bus.out_data      = out_data_q;
    assign bus.readReady     = read_ready_q;
    assign bus.writeComplete = write_complete_q;
    assign bus.busy          = busy_q;
    assign bus.fill_count    = fill_q;

endmodule

// File: tb/tb_audio_loop_buffer.sv
// Directed bench for audio_loop_buffer with DEPTH=8, CHANNELS=2, DATA_W=24.
module tb_audio_loop_buffer;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   rr_count;

    audio_loop_buffer_if #(.DATA_W(24), .CHANNELS(2), .DEPTH(8)) bus ();

    audio_loop_buffer #(.DATA_W(24), .CHANNELS(2), .DEPTH(8)) dut (
        .clk   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count readReady cycles, sampled away from the active edge.
    initial rr_count = 0;
    always @(negedge clk) begin
        if (bus.readReady === 1'b1) rr_count++;
    end

    function automatic logic [47:0] frame(input int unsigned base_hi, input int unsigned base_lo,
                                          input int unsigned i);
        return {24'(base_hi + i), 24'(base_lo + i)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [47:0] data);
        bus.in_data    = data;
        bus.new_sample = 1'b1;
        tick();
        bus.new_sample = 1'b0;
        tick();
    endtask

    task automatic pulse_write();
        bus.start_write = 1'b1;
        tick();
        bus.start_write = 1'b0;
    endtask

    task automatic pulse_read(input logic loop);
        bus.loop_en    = loop;
        bus.start_read = 1'b1;
        tick();
        bus.start_read = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    initial begin
        int rr_base;
        n_tests         = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus.new_sample  = 1'b0;
        bus.start_write = 1'b0;
        bus.start_read  = 1'b0;
        bus.stop        = 1'b0;
        bus.loop_en     = 1'b0;
        bus.in_data     = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_out_data", 64'(bus.out_data), 64'h0);
        check("rst_ready", 64'(bus.readReady), 64'h0);
        check("rst_wc", 64'(bus.writeComplete), 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_fill", 64'(bus.fill_count), 64'h0);

        // start_read with nothing recorded is ignored
        pulse_read(1'b0);
        tick();
        check("empty_read_busy", 64'(bus.busy), 64'h0);

        // full 8-frame recording
        pulse_write();
        check("rec_busy", 64'(bus.busy), 64'h1);
        for (int i = 0; i < 8; i++) begin
            sample(frame(32'h100, 32'h0, i));
            if (i == 3) begin
                check("rec_fill_mid", 64'(bus.fill_count), 64'd4);
                check("rec_wc_mid", 64'(bus.writeComplete), 64'h0);
            end
        end
        check("full_fill", 64'(bus.fill_count), 64'd8);
        check("full_wc", 64'(bus.writeComplete), 64'h1);
        check("full_busy", 64'(bus.busy), 64'h0);

        // single playback
        rr_base = rr_count;
        pulse_read(1'b0);
        check("play_busy", 64'(bus.busy), 64'h1);
        for (int i = 0; i < 8; i++) begin
            sample(48'h0);
            check($sformatf("play_data%0d", i), 64'(bus.out_data), 64'(frame(32'h100, 32'h0, i)));
            check($sformatf("play_ready%0d", i), 64'(bus.readReady), 64'h1);
        end
        check("play_end_busy", 64'(bus.busy), 64'h0);
        sample(48'h0);
        check("play_pulses", 64'(rr_count - rr_base), 64'd8);
        check("idle_hold", 64'(bus.out_data), 64'(frame(32'h100, 32'h0, 7)));

        // 5-frame recording ended by stop
        pulse_write();
        for (int i = 0; i < 5; i++) sample(frame(32'h200, 32'h50, i));
        pulse_stop();
        check("rec5_fill", 64'(bus.fill_count), 64'd5);
        check("rec5_wc", 64'(bus.writeComplete), 64'h1);
        check("rec5_busy", 64'(bus.busy), 64'h0);

        // looped playback over 12 events, then stop
        rr_base = rr_count;
        pulse_read(1'b1);
        for (int i = 0; i < 12; i++) begin
            sample(48'h0);
            check($sformatf("loop_data%0d", i), 64'(bus.out_data), 64'(frame(32'h200, 32'h50, i % 5)));
        end
        check("loop_busy", 64'(bus.busy), 64'h1);
        pulse_stop();
        tick();
        check("loop_stop_busy", 64'(bus.busy), 64'h0);
        check("loop_stop_data", 64'(bus.out_data), 64'(frame(32'h200, 32'h50, 1)));
        check("loop_pulses", 64'(rr_count - rr_base), 64'd12);

        // simultaneous start_write and start_read: recording wins
        bus.start_read = 1'b1;
        pulse_write();
        bus.start_read = 1'b0;
        check("both_busy", 64'(bus.busy), 64'h1);
        check("both_fill", 64'(bus.fill_count), 64'd0);
        check("both_wc", 64'(bus.writeComplete), 64'h0);
        for (int i = 0; i < 3; i++) sample(frame(32'h300, 32'h30, i));
        pulse_stop();
        check("rec3_fill", 64'(bus.fill_count), 64'd3);

        // start_write during playback is ignored
        pulse_read(1'b0);
        sample(48'h0);
        check("ign_data0", 64'(bus.out_data), 64'(frame(32'h300, 32'h30, 0)));
        pulse_write();
        tick();
        sample(48'h0);
        check("ign_data1", 64'(bus.out_data), 64'(frame(32'h300, 32'h30, 1)));
        check("ign_fill", 64'(bus.fill_count), 64'd3);
        sample(48'h0);
        check("ign_data2", 64'(bus.out_data), 64'(frame(32'h300, 32'h30, 2)));
        check("ign_end_busy", 64'(bus.busy), 64'h0);

        // reset in the middle of looped playback
        pulse_read(1'b1);
        sample(48'h0);
        sample(48'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_data", 64'(bus.out_data), 64'h0);
        check("mid_rst_ready", 64'(bus.readReady), 64'h0);
        check("mid_rst_fill", 64'(bus.fill_count), 64'h0);
        check("mid_rst_wc", 64'(bus.writeComplete), 64'h0);
        check("mid_rst_busy", 64'(bus.busy), 64'h0);
        rr_base = rr_count;
        pulse_read(1'b0);
        tick();
        check("post_rst_busy", 64'(bus.busy), 64'h0);
        sample(48'h0);
        tick();
        check("post_rst_pulses", 64'(rr_count - rr_base), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_loop_buffer.md
# audio_loop_buffer

Parametrised record/playback sample buffer for the audio path. It sits between the codec sample interface and the output stage. It captures multi-channel audio frames, one per sample strobe, into an on-chip RAM. It then plays the frames back once or in a continuous loop. It generalises the fixed two-channel, 24-bit record/playback block by adding configurable width, depth and channel count, variable-length recording, early stop, loop mode and fill reporting.

## Interface
- DATA_W, 24: bits per channel sample
- CHANNELS, 2: channels per frame; channel 0 in LSBs (0 = left, 1 = right)
- DEPTH, 1024: frames of storage; power of two, ≥ 2
- AW, $clog2(DEPTH): address width (derived, not overridden)

Ports:
- clk  in  1  single system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- new_sample  in  1  sample-rate strobe/toggle; a sample event is its rising edge
- start_write  in  1  rising edge starts a recording
- start_read  in  1  rising edge starts playback
- stop  in  1  level; ends recording or playback at the next clock edge
- loop_en  in  1  sampled at playback start; 1 = wrap and repeat
- in_data  in  CHANNELS*DATA_W  frame to record
- out_data  out  CHANNELS*DATA_W  played-back frame; reset 0
- readReady  out  1  1-cycle pulse when out_data updates; reset 0
- writeComplete  out  1  level: a recording of length ≥ 1 is held; reset 0
- busy  out  1  1 in RECORD or PLAY; reset 0
- fill_count  out  AW+1  recorded length in frames; reset 0

## Operation
- Edge detection: registers new_sample, start_write and start_read. An event = input 1 at edge k and 0 at edge k-1. The first edge after RESET sees a previous value of 0.
- States: IDLE, RECORD, PLAY.
- IDLE → RECORD on a start_write event:
  - clears wr_addr, fill_count and writeComplete.
  - start_write and start_read events in the same cycle: write wins.
- RECORD: each sample event writes in_data to RAM[wr_addr], increments wr_addr and increments fill_count.
- RECORD → IDLE when either:
  - the DEPTH-th frame is written (fill_count = DEPTH), or
  - stop = 1. A sample event in the same cycle as stop is still written.
- On RECORD → IDLE, writeComplete = (fill_count ≠ 0).
- IDLE → PLAY on a start_read event when fill_count ≠ 0:
  - rd_addr = 0, loop latched from loop_en.
  - With fill_count = 0 the event is ignored.
- PLAY: each sample event reads RAM[rd_addr] and advances rd_addr.
- At the last frame (rd_addr = fill_count-1):
  - loop = 1: rd_addr wraps to 0.
  - loop = 0: → IDLE after issuing that read.
- PLAY → IDLE also on stop = 1. A read issued in that cycle still completes.
- start_write and start_read events are ignored outside IDLE.
- out_data holds its last value in IDLE.
- RESET mid-operation: state IDLE, all outputs and counters to reset values. RAM contents are not cleared but are unreachable (fill_count = 0).

## Timing
- Record: frame written at the same edge k as the sample event. No output latency.
- Playback: RAM read at edge k, out_data registered at edge k+1, readReady high for the cycle following edge k+1.
- Trailing read: if stop or end-of-playback takes state to IDLE at edge k, the out_data/readReady update at edge k+1 still happens.
- busy: rises one cycle after the start event and falls one cycle after the stop condition.
- Back-to-back sample events must be ≥ 2 cycles apart (rising edges); closer events are undefined.
- Throughput: one frame per sample event. No stalls.

## Structure
- Package audio_pkg:
  - state enum {IDLE, RECORD, PLAY}
  - default DATA_W/CHANNELS/DEPTH constants
  - frame-width helper function
- Sub-module audio_frame_ram:
  - simple dual-port synchronous RAM, one write port and one registered read port
  - width CHANNELS*DATA_W, depth DEPTH, inferable as block RAM
- Top: edge detectors, FSM, address/fill counters, output register.

## Test plan
Bench uses DEPTH=8, CHANNELS=2, DATA_W=24.
- Full record: start_write, 8 sample events with in_data = {ch1 = 0x000100+i, ch0 = 0x000000+i} for i = 0..7 → fill_count 8, writeComplete 1, busy 0 after the 8th event.
- Single playback: start_read with loop_en = 0 → 8 readReady pulses, out_data matches frames 0..7 in order at event+2 cycles, then busy 0.
- Loop playback: 5-frame recording (stop after 5th event), start_read with loop_en = 1, 12 events → frames 0,1,2,3,4,0,1,…,1; stop → busy 0 with out_data = frame 1.
- Corner starts: start_read with fill_count = 0 → no state change. start_write and start_read in the same cycle → RECORD.
- Reset in PLAY mid-stream → out_data 0, readReady 0, fill_count 0, writeComplete 0. A following start_read is ignored.
- Ignored start: start_write event during PLAY → ignored; playback sequence continues unchanged.
